alu_req_arbiter: RTL and testbench

- Shares the single-cycle ALU between two requesters, e.g. the execute stage (port 0) and a debug/test master (port 1).
- Arbitrates between them round-robin and drives one external ALU instance from registered operands.
- Holds multiply for a configurable number of cycles, since MUL is the long combinational path.
- Returns a registered result, zero flag and requester ID through a valid/ready response handshake.

---
 rtl/alu_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one external single-cycle ALU between two requesters.
// Round-robin grant in IDLE, operands held in registers for the EXEC phase
// (stretched for MUL), and a registered result returned through a
// valid/ready response handshake. Only one operation is ever in flight.
module alu_req_arbiter #(
    parameter int MUL_LAT = 3,
    parameter int ID_W    = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [31:0]     req0_src1_i,
    input  logic [31:0]     req0_src2_i,
    input  logic [3:0]      req0_ctrl_i,

    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [31:0]     req1_src1_i,
    input  logic [31:0]     req1_src2_i,
    input  logic [3:0]      req1_ctrl_i,

    output logic [31:0]     alu_src1_o,
    output logic [31:0]     alu_src2_o,
    output logic [3:0]      alu_ctrl_o,
    input  logic [31:0]     alu_result_i,
    input  logic            alu_zero_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [ID_W-1:0] rsp_id_o,
    output logic [31:0]     rsp_result_o,
    output logic            rsp_zero_o,
    output logic            rsp_err_o
);

    localparam logic [3:0] CTRL_MUL = 4'b1001;
    // MUL_LAT is 1..15, so MUL_LAT-1 always fits the 4-bit hold counter.
    localparam logic [3:0] MUL_HOLD = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            prio_q;      // requester that wins when both are valid
    logic [3:0]      cnt_q;       // remaining extra EXEC cycles
    logic [ID_W-1:0] id_q;        // requester owning the in-flight operation

    logic            gnt_any;
    logic            gnt_sel;
    logic [31:0]     gnt_src1;
    logic [31:0]     gnt_src2;
    logic [3:0]      gnt_ctrl;

    // Decodes the set of control codes the ALU implements.
    function automatic logic is_legal(input logic [3:0] ctrl);
        logic ok;
        case (ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1001: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin grant and operand select; a grant only exists in IDLE.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt_any = 1'b1;
                gnt_sel = prio_q;
            end else if (req0_valid_i) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (req1_valid_i) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end
        gnt_src1 = gnt_sel ? req1_src1_i : req0_src1_i;
        gnt_src2 = gnt_sel ? req1_src2_i : req0_src2_i;
        gnt_ctrl = gnt_sel ? req1_ctrl_i : req0_ctrl_i;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_any)      state_d = S_EXEC;
            S_EXEC:  if (cnt_q == '0)  state_d = S_RESP;
            S_RESP:  if (rsp_ready_i)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state and grant.
    always_comb begin
        req0_ready_o = gnt_any && !gnt_sel;
        req1_ready_o = gnt_any &&  gnt_sel;
        rsp_valid_o  = (state_q == S_RESP);
    end

    // Operand, counter, priority and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            id_q         <= '0;
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            alu_ctrl_o   <= 4'b0000;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_err_o    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        alu_src1_o <= gnt_src1;
                        alu_src2_o <= gnt_src2;
                        alu_ctrl_o <= gnt_ctrl;
                        id_q       <= ID_W'(gnt_sel);
                        prio_q     <= ~gnt_sel;
                        cnt_q      <= (gnt_ctrl == CTRL_MUL) ? MUL_HOLD : 4'd0;
                    end
                end
                S_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_id_o <= id_q;
                        if (is_legal(alu_ctrl_o)) begin
                            rsp_result_o <= alu_result_i;
                            rsp_zero_o   <= alu_zero_i;
                            rsp_err_o    <= 1'b0;
                        end else begin
                            // ALU output is meaningless for an unknown code.
                            rsp_result_o <= '0;
                            rsp_zero_o   <= 1'b1;
                            rsp_err_o    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: models the external ALU, drives requests from a
// vector table plus hand-written contention / backpressure / reset sequences,
// and checks responses against a scoreboard queue.
module tb_alu_req_arbiter;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_err;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        id;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    vec_t tab[13];

    alu_req_arbiter #(.MUL_LAT(MUL_LAT), .ID_W(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_src1_i(req0_src1), .req0_src2_i(req0_src2), .req0_ctrl_i(req0_ctrl),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_src1_i(req1_src1), .req1_src2_i(req1_src2), .req1_ctrl_i(req1_ctrl),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;

    // External ALU; unknown codes return garbage the arbiter must ignore.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: alu_result = alu_src1 + alu_src2;
            4'b0011: alu_result = alu_src1 - alu_src2;
            4'b0100: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
            4'b0101: alu_result = alu_src1 << alu_src2[4:0];
            4'b0110: alu_result = alu_src1 >> alu_src2[4:0];
            4'b0111: alu_result = {alu_src2[15:0], 16'h0000};
            4'b1001: alu_result = alu_src1 * alu_src2;
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every accepted response must match the queue head.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got id %0d result %h expected no response",
                         rsp_id, rsp_result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_result", rsp_result, e.res);
                check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic drive_req(input logic id, input logic [31:0] s1, input logic [31:0] s2,
                             input logic [3:0] c, input logic v);
        if (id == 1'b0) begin
            req0_valid = v; req0_src1 = s1; req0_src2 = s2; req0_ctrl = c;
        end else begin
            req1_valid = v; req1_src1 = s1; req1_src2 = s2; req1_ctrl = c;
        end
    endtask

    // Waits (bounded) for the given requester's ready; returns at the negedge it is seen.
    task automatic wait_ready(input logic id, output logic got);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    // Issues one vector alone, checks operand hold and latency to rsp_valid.
    task automatic run_vec(input vec_t v);
        logic got;
        int   n;
        drive_req(v.id, v.s1, v.s2, v.ctrl, 1'b1);
        wait_ready(v.id, got);
        check("grant", 32'(got), 32'd1);
        if (!got) begin
            drive_req(v.id, v.s1, v.s2, v.ctrl, 1'b0);
            return;
        end
        check("other_ready", 32'(v.id ? req0_ready : req1_ready), 32'd0);
        sbq.push_back('{v.id, v.res, v.zero, v.err});
        @(posedge clk); #1;
        drive_req(v.id, 32'h0, 32'h0, 4'h0, 1'b0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            check("hold_src1", alu_src1, v.s1);
            check("hold_ctrl", 32'(alu_ctrl), 32'(v.ctrl));
            @(posedge clk); #1;
            n++;
        end
        // Valid is visible just after the edge following the last EXEC cycle.
        check("latency", n, (v.ctrl == 4'b1001) ? MUL_LAT : 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic got;
        logic [31:0] r_res;
        int exp_rr [3] = '{0, 1, 0};
        int stray;

        tab[0]  = '{1'b0, 32'd5,         32'd7,         4'b0010, 32'd12,        1'b0, 1'b0};
        tab[1]  = '{1'b0, 32'd9,         32'd9,         4'b0011, 32'd0,         1'b1, 1'b0};
        tab[2]  = '{1'b1, 32'hF0F0F0F0,  32'hFF00FF00,  4'b0000, 32'hF000F000,  1'b0, 1'b0};
        tab[3]  = '{1'b1, 32'h0000000F,  32'h000000F0,  4'b0001, 32'h000000FF,  1'b0, 1'b0};
        tab[4]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         4'b0100, 32'd1,         1'b0, 1'b0};
        tab[5]  = '{1'b1, 32'd1,         32'd4,         4'b0101, 32'd16,        1'b0, 1'b0};
        tab[6]  = '{1'b0, 32'h80000000,  32'd31,        4'b0110, 32'd1,         1'b0, 1'b0};
        tab[7]  = '{1'b1, 32'd0,         32'h00001234,  4'b0111, 32'h12340000,  1'b0, 1'b0};
        tab[8]  = '{1'b1, 32'd6,         32'd7,         4'b1001, 32'd42,        1'b0, 1'b0};
        tab[9]  = '{1'b0, 32'h00010000,  32'h00010000,  4'b1001, 32'd0,         1'b1, 1'b0};
        tab[10] = '{1'b0, 32'hFFFFFFFF,  32'd1,         4'b0010, 32'd0,         1'b1, 1'b0};
        tab[11] = '{1'b0, 32'd3,         32'd4,         4'b1111, 32'd0,         1'b1, 1'b1};
        tab[12] = '{1'b1, 32'd3,         32'd4,         4'b1000, 32'd0,         1'b1, 1'b1};

        rst = 1'b1;
        rsp_ready = 1'b1;
        drive_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive_req(1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_alu_src1", alu_src1, 32'd0);
        check("rst_alu_src2", alu_src2, 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_flags", {29'd0, rsp_id, rsp_zero, rsp_err}, 32'd0);

        // Table of single-requester operations.
        for (int i = 0; i < 13; i++) run_vec(tab[i]);
        wait_drain();

        // Contention: both valid continuously, grants must alternate 0,1,0.
        drive_req(1'b0, 32'd9, 32'd9, 4'b0011, 1'b1);
        drive_req(1'b1, 32'd9, 32'd9, 4'b0011, 1'b1);
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                if (req0_ready === 1'b1 || req1_ready === 1'b1) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check("rr_seen", 32'(got), 32'd1);
            check("rr_one_hot", 32'(req0_ready & req1_ready), 32'd0);
            check("rr_grant", 32'(req1_ready), 32'(exp_rr[k]));
            sbq.push_back('{req1_ready, 32'd0, 1'b1, 1'b0});
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();
        @(posedge clk); #1;

        // Backpressure: response held 5 cycles while a new request waits.
        rsp_ready = 1'b0;
        drive_req(1'b0, 32'd1, 32'd2, 4'b0010, 1'b1);
        wait_ready(1'b0, got);
        check("bp_grant", 32'(got), 32'd1);
        sbq.push_back('{1'b0, 32'd3, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive_req(1'b0, 32'd3, 32'd4, 4'b0010, 1'b1);
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        r_res = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", rsp_result, r_res);
            check("bp_id_zero_err", {29'd0, rsp_id, rsp_zero, rsp_err}, 32'd0);
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_accept_after_hs", 32'(req0_ready), 32'd1);
        sbq.push_back('{1'b0, 32'd7, 1'b0, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_drain();
        @(posedge clk); #1;

        // Reset during a MUL in EXEC: operation dropped, no response.
        drive_req(1'b1, 32'd6, 32'd7, 4'b1001, 1'b1);
        wait_ready(1'b1, got);
        check("mr_grant", 32'(got), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("mr_in_exec", 32'(alu_ctrl), 32'h9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("mr_alu_src1", alu_src1, 32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stray++;
        end
        check("mr_no_rsp", stray, 0);
        @(posedge clk); #1;

        // Normal operation after the reset; priority back to requester 0.
        run_vec(tab[0]);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
